// File: rtl/rule110_pkg.sv
// Shared encodings for the rule110 host sequencer: command opcodes, FSM states, block width.
package rule110_pkg;

    localparam int CELLS_PER_BLOCK = 8;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_LOAD = 2'd1,
        OP_RUN  = 2'd2,
        OP_DUMP = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LOAD_WR,
        RUN,
        DUMP_ADDR,
        DUMP_OUT
    } state_e;

endpackage

// File: rtl/rule110_blk_ctr.sv
// Block address counter shared by LOAD and DUMP; wraps to 0 after the final block.
module rule110_blk_ctr #(
    parameter int NUM_BLOCKS = 32,
    parameter int ADDR_W     = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    assign last = (addr_q == ADDR_W'(NUM_BLOCKS - 1));
    assign addr = addr_q;

    always_comb begin
        addr_d = addr_q;
        if (clr) begin
            addr_d = '0;
        end else if (inc) begin
            addr_d = last ? '0 : addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/rule110_sequencer.sv
// Host-side LOAD / RUN / DUMP controller for the rule110 cell array; all outputs registered.
// Optional macro RULE110_SEQ_AUTODUMP_EN: a finished RUN flows straight into a full DUMP.
module rule110_sequencer
    import rule110_pkg::*;
#(
    parameter int NUM_BLOCKS = 32,
    parameter int ADDR_W     = 6,
    parameter int GEN_W      = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [GEN_W-1:0]           cmd_gens,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CELLS_PER_BLOCK-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CELLS_PER_BLOCK-1:0] out_data,
    output logic                       out_last,
    output logic                       ca_we_n,
    output logic                       ca_halt_n,
    output logic [ADDR_W-1:0]          ca_addr,
    output logic [CELLS_PER_BLOCK-1:0] ca_data_in,
    input  logic [CELLS_PER_BLOCK-1:0] ca_data_out,
    output logic                       busy,
    output logic [GEN_W-1:0]           gen_count
);

    state_e                       state_q, state_d;
    logic                         cmd_ready_q, cmd_ready_d;
    logic                         in_ready_q, in_ready_d;
    logic                         out_valid_q, out_valid_d;
    logic [CELLS_PER_BLOCK-1:0]   out_data_q, out_data_d;
    logic                         out_last_q, out_last_d;
    logic                         ca_we_n_q, ca_we_n_d;
    logic                         ca_halt_n_q, ca_halt_n_d;
    logic [CELLS_PER_BLOCK-1:0]   ca_data_in_q, ca_data_in_d;
    logic                         busy_q, busy_d;
    logic [GEN_W-1:0]             gen_count_q, gen_count_d;
    logic [GEN_W-1:0]             gens_left_q, gens_left_d;

    logic                         blk_clr;
    logic                         blk_inc;
    logic                         blk_last;
    logic [ADDR_W-1:0]            blk_addr;

    // The counter flop itself is the registered ca_addr.
    rule110_blk_ctr #(
        .NUM_BLOCKS(NUM_BLOCKS),
        .ADDR_W    (ADDR_W)
    ) u_blk_ctr (
        .clk  (clk),
        .reset(reset),
        .clr  (blk_clr),
        .inc  (blk_inc),
        .addr (blk_addr),
        .last (blk_last)
    );

    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        ca_we_n_d    = 1'b1;
        ca_halt_n_d  = 1'b0;
        ca_data_in_d = ca_data_in_q;
        gen_count_d  = gen_count_q;
        gens_left_d  = gens_left_q;
        blk_clr      = 1'b0;
        blk_inc      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    case (op_e'(cmd_op))
                        OP_LOAD: begin
                            state_d = LOAD;
                            blk_clr = 1'b1;
                        end
                        OP_RUN: begin
                            if (cmd_gens != '0) begin
                                state_d     = RUN;
                                gens_left_d = cmd_gens;
                                ca_halt_n_d = 1'b1;
                            end else begin
`ifdef RULE110_SEQ_AUTODUMP_EN
                                state_d = DUMP_ADDR;
                                blk_clr = 1'b1;
`endif
                            end
                        end
                        OP_DUMP: begin
                            state_d = DUMP_ADDR;
                            blk_clr = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            LOAD: begin
                if (in_valid && in_ready_q) begin
                    state_d      = LOAD_WR;
                    ca_data_in_d = in_data;
                    ca_we_n_d    = 1'b0;
                end
            end
            LOAD_WR: begin
                blk_inc = 1'b1;
                if (blk_last) begin
                    state_d     = IDLE;
                    gen_count_d = '0;
                end else begin
                    state_d = LOAD;
                end
            end
            RUN: begin
                if (gen_count_q != '1) begin
                    gen_count_d = gen_count_q + GEN_W'(1);
                end
                gens_left_d = gens_left_q - GEN_W'(1);
                if (gens_left_q == GEN_W'(1)) begin
`ifdef RULE110_SEQ_AUTODUMP_EN
                    state_d = DUMP_ADDR;
                    blk_clr = 1'b1;
`else
                    state_d = IDLE;
`endif
                end else begin
                    ca_halt_n_d = 1'b1;
                end
            end
            DUMP_ADDR: begin
                // ca_data_out is combinational from ca_addr, so it is valid in this cycle.
                state_d     = DUMP_OUT;
                out_data_d  = ca_data_out;
                out_valid_d = 1'b1;
                out_last_d  = blk_last;
            end
            DUMP_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        state_d = IDLE;
                    end else begin
                        blk_inc = 1'b1;
                        state_d = DUMP_ADDR;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        in_ready_d  = (state_d == LOAD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cmd_ready_q  <= 1'b1;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            ca_we_n_q    <= 1'b1;
            ca_halt_n_q  <= 1'b0;
            ca_data_in_q <= '0;
            busy_q       <= 1'b0;
            gen_count_q  <= '0;
            gens_left_q  <= '0;
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            ca_we_n_q    <= ca_we_n_d;
            ca_halt_n_q  <= ca_halt_n_d;
            ca_data_in_q <= ca_data_in_d;
            busy_q       <= busy_d;
            gen_count_q  <= gen_count_d;
            gens_left_q  <= gens_left_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign ca_we_n    = ca_we_n_q;
    assign ca_halt_n  = ca_halt_n_q;
    assign ca_addr    = blk_addr;
    assign ca_data_in = ca_data_in_q;
    assign busy       = busy_q;
    assign gen_count  = gen_count_q;

endmodule

// File: tb/tb_rule110_sequencer.sv
// Directed bench for rule110_sequencer driving a 256-cell rule 110 array model (circular boundary).
module tb_rule110_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [15:0] cmd_gens = 16'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic        out_last;
    logic        ca_we_n;
    logic        ca_halt_n;
    logic [5:0]  ca_addr;
    logic [7:0]  ca_data_in;
    logic [7:0]  ca_data_out;
    logic        busy;
    logic [15:0] gen_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rule110_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_gens   (cmd_gens),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .ca_we_n    (ca_we_n),
        .ca_halt_n  (ca_halt_n),
        .ca_addr    (ca_addr),
        .ca_data_in (ca_data_in),
        .ca_data_out(ca_data_out),
        .busy       (busy),
        .gen_count  (gen_count)
    );

    function automatic logic [255:0] step(input logic [255:0] c);
        logic [255:0] n;
        logic [7:0]   rule;
        logic [2:0]   idx;
        rule = 8'd110;
        for (int i = 0; i < 256; i++) begin
            idx  = {c[(i + 1) % 256], c[i], c[(i + 255) % 256]};
            n[i] = rule[idx];
        end
        return n;
    endfunction

    function automatic logic [255:0] step_n(input logic [255:0] c, input int n);
        logic [255:0] r;
        r = c;
        for (int i = 0; i < n; i++) r = step(r);
        return r;
    endfunction

    // Array model: cells start non-trivial so an illegal advance would be visible.
    logic [255:0] cells = 256'h0123_4567_89ab_cdef_0000_0000_0000_0001_8000_0000_0000_0000_fedc_ba98_7654_3210;
    logic [255:0] nxt_view;
    assign nxt_view = step(cells);
    assign ca_data_out = nxt_view[{ca_addr[4:0], 3'b000} +: 8];

    always @(posedge clk) begin
        if (!ca_we_n) cells[{ca_addr[4:0], 3'b000} +: 8] <= ca_data_in;
        else if (ca_halt_n) cells <= step(cells);
    end

    int         we_cnt = 0;
    int         halt_cnt = 0;
    logic [5:0] we_addr [64];
    logic [7:0] we_data [64];
    always @(negedge clk) begin
        if (!ca_we_n) begin
            if (we_cnt < 64) begin
                we_addr[we_cnt] = ca_addr;
                we_data[we_cnt] = ca_data_in;
            end
            we_cnt++;
        end
        if (ca_halt_n) halt_cnt++;
    end

    logic [255:0] loaded;
    logic [255:0] gen5;

    task automatic send_cmd(input logic [1:0] op, input logic [15:0] gens);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_cmd_ready op=%0d: got cmd_ready=%b want 1", op, cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_gens  = gens;
        @(negedge clk);
        cmd_valid = 1'b0;
        $display("cmd op=%0d gens=%0d issued", op, gens);
    endtask

    task automatic wait_idle(input int max_cycles, input string name);
        int t = 0;
        while (busy && t < max_cycles) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (busy) begin
            failures++;
            $display("FAIL %s_timeout: busy still 1 after %0d cycles, want 0", name, max_cycles);
        end
    endtask

    task automatic test_reset();
        logic [255:0] snap;
        int h0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks += 6;
        if (ca_halt_n !== 1'b0) begin failures++; $display("FAIL reset_halt_n: got %b want 0", ca_halt_n); end
        if (ca_we_n !== 1'b1) begin failures++; $display("FAIL reset_we_n: got %b want 1", ca_we_n); end
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        if (gen_count !== 16'd0) begin failures++; $display("FAIL reset_gen_count: got %0d want 0", gen_count); end
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            failures++; $display("FAIL reset_busy_in_ready: got busy=%b in_ready=%b want 0/0", busy, in_ready);
        end
        if (out_valid !== 1'b0 || out_last !== 1'b0 || ca_addr !== 6'd0) begin
            failures++; $display("FAIL reset_outs: got out_valid=%b out_last=%b ca_addr=%0d want 0/0/0", out_valid, out_last, ca_addr);
        end
        snap = cells;
        h0 = halt_cnt;
        repeat (100) @(negedge clk);
        checks += 2;
        if (cells !== snap) begin failures++; $display("FAIL reset_idle_hold: array changed %h want %h", cells, snap); end
        if (halt_cnt != h0) begin failures++; $display("FAIL reset_idle_halt: got %0d halt cycles want 0", halt_cnt - h0); end
        $display("reset: idle 100 cycles done");
    endtask

    task automatic test_load();
        logic [7:0] bytes [32];
        int w0, t;
        for (int b = 0; b < 32; b++) bytes[b] = (b == 31) ? 8'h80 : 8'h00;
        loaded = '0;
        loaded[255] = 1'b1;
        w0 = we_cnt;
        send_cmd(2'd1, 16'd0);
        in_valid = 1'b1;
        for (int b = 0; b < 32; b++) begin
            in_data = bytes[b];
            t = 0;
            while (!in_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (t >= 20) begin
                checks++; failures++;
                $display("FAIL load_in_ready_timeout block=%0d: in_ready=0 want 1", b);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        wait_idle(10, "load");
        checks += 3;
        if (we_cnt - w0 != 32) begin failures++; $display("FAIL load_we_pulses: got %0d want 32", we_cnt - w0); end
        if (cells !== loaded) begin failures++; $display("FAIL load_array: got %h want %h", cells, loaded); end
        if (gen_count !== 16'd0) begin failures++; $display("FAIL load_gen_count: got %0d want 0", gen_count); end
        for (int b = 0; b < 32 && (w0 + b) < 64; b++) begin
            checks++;
            if (we_addr[w0 + b] !== 6'(b) || we_data[w0 + b] !== bytes[b]) begin
                failures++;
                $display("FAIL load_write%0d: got addr=%0d data=%h want addr=%0d data=%h",
                         b, we_addr[w0 + b], we_data[w0 + b], b, bytes[b]);
            end
        end
        $display("load: %0d writes", we_cnt - w0);
    endtask

    task automatic test_run();
        int h0;
        h0 = halt_cnt;
        send_cmd(2'd2, 16'd5);
        wait_idle(50, "run5");
        gen5 = step_n(loaded, 5);
        checks += 3;
        if (halt_cnt - h0 != 5) begin failures++; $display("FAIL run5_halt_cycles: got %0d want 5", halt_cnt - h0); end
        if (gen_count !== 16'd5) begin failures++; $display("FAIL run5_gen_count: got %0d want 5", gen_count); end
        if (cells !== gen5) begin failures++; $display("FAIL run5_array: got %h want %h", cells, gen5); end
        $display("run gens=5: halt cycles=%0d gen_count=%0d", halt_cnt - h0, gen_count);
        h0 = halt_cnt;
        send_cmd(2'd2, 16'd0);
`ifndef RULE110_SEQ_AUTODUMP_EN
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL run0_stay_idle: got cmd_ready=%b busy=%b want 1/0", cmd_ready, busy);
        end
`endif
        repeat (3) @(negedge clk);
        wait_idle(200, "run0");
        checks += 2;
        if (halt_cnt != h0) begin failures++; $display("FAIL run0_halt_cycles: got %0d want 0", halt_cnt - h0); end
        if (gen_count !== 16'd5) begin failures++; $display("FAIL run0_gen_count: got %0d want 5", gen_count); end
        // A NOP must be consumed without side effects.
        send_cmd(2'd0, 16'd7);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || gen_count !== 16'd5 || halt_cnt != h0) begin
            failures++; $display("FAIL nop_no_effect: got busy=%b gen_count=%0d want 0/5", busy, gen_count);
        end
        $display("run gens=0 and nop done");
    endtask

    task automatic test_dump();
        logic [255:0] expv;
        logic [7:0]   held_data;
        logic         held_last;
        logic         stalled;
        int got, t;
        expv = step_n(loaded, 6);
        out_ready = 1'b0;
        send_cmd(2'd3, 16'd0);
        got = 0; t = 0; stalled = 1'b0;
        while (got < 32 && t < 500) begin
            @(negedge clk);
            t++;
            out_ready = ~out_ready;
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held_data || out_last !== held_last) begin
                    failures++;
                    $display("FAIL dump_stall_stable byte=%0d: got v=%b d=%h l=%b want 1/%h/%b",
                             got, out_valid, out_data, out_last, held_data, held_last);
                end
                stalled = 1'b0;
            end
            if (out_valid) begin
                if (out_ready) begin
                    checks++;
                    if (out_data !== expv[got*8 +: 8] || out_last !== (got == 31)) begin
                        failures++;
                        $display("FAIL dump_byte%0d: got data=%h last=%b want data=%h last=%b",
                                 got, out_data, out_last, expv[got*8 +: 8], (got == 31));
                    end
                    $display("dump byte %0d = %h last=%b", got, out_data, out_last);
                    got++;
                end else begin
                    stalled   = 1'b1;
                    held_data = out_data;
                    held_last = out_last;
                end
            end
        end
        out_ready = 1'b1;
        checks++;
        if (got != 32) begin failures++; $display("FAIL dump_count: got %0d bytes want 32", got); end
        wait_idle(10, "dump");
        checks += 2;
        if (cells !== gen5) begin failures++; $display("FAIL dump_array_held: got %h want %h", cells, gen5); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL dump_out_valid_idle: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_run();
        logic [255:0] snap;
        int h0, k;
        h0 = halt_cnt;
        send_cmd(2'd2, 16'd1000);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        k = halt_cnt - h0;
        checks += 4;
        if (ca_halt_n !== 1'b0) begin failures++; $display("FAIL midrun_halt_n: got %b want 0", ca_halt_n); end
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++; $display("FAIL midrun_idle: got busy=%b cmd_ready=%b want 0/1", busy, cmd_ready);
        end
        if (k < 10 || k > 11) begin failures++; $display("FAIL midrun_gens: got %0d halt cycles want 10..11", k); end
        if (cells !== step_n(gen5, k)) begin failures++; $display("FAIL midrun_array: array not at generation %0d", 5 + k); end
        snap = cells;
        repeat (20) @(negedge clk);
        checks++;
        if (cells !== snap || halt_cnt - h0 != k) begin
            failures++; $display("FAIL midrun_no_advance: got %0d extra halt cycles want 0", halt_cnt - h0 - k);
        end
        $display("reset mid-run: %0d generations ran", k);
    endtask

`ifdef RULE110_SEQ_AUTODUMP_EN
    task automatic test_autodump();
        logic [255:0] base;
        logic [255:0] expv;
        int got, t;
        base = cells;
        expv = step_n(base, 4);
        out_ready = 1'b1;
        send_cmd(2'd2, 16'd3);
        got = 0; t = 0;
        while (got < 32 && t < 500) begin
            @(negedge clk);
            t++;
            if (got < 31) begin
                checks++;
                if (cmd_ready !== 1'b0) begin failures++; $display("FAIL autodump_cmd_ready byte=%0d: got 1 want 0", got); end
            end
            if (out_valid) begin
                checks++;
                if (out_data !== expv[got*8 +: 8] || out_last !== (got == 31)) begin
                    failures++;
                    $display("FAIL autodump_byte%0d: got data=%h last=%b want data=%h", got, out_data, out_last, expv[got*8 +: 8]);
                end
                got++;
            end
        end
        checks++;
        if (got != 32) begin failures++; $display("FAIL autodump_count: got %0d want 32", got); end
        wait_idle(10, "autodump");
        $display("autodump: %0d bytes", got);
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_run();
        test_dump();
        test_reset_mid_run();
`ifdef RULE110_SEQ_AUTODUMP_EN
        test_autodump();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
